// File: rtl/adder_result_buffer_pkg.sv
// ---------------------------------------------------------------------------
// adder_result_buffer_pkg
//   Shared constants for the 4-stage pipeline adder and its result buffer:
//   result width, adder latency, default FIFO depth and the {cout,sum}
//   result layout.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package adder_result_buffer_pkg;

  localparam int ADDER_DATA_W = 32;
  localparam int ADDER_LAT    = 4;
  localparam int RESBUF_DEPTH = 8;

  // One adder result as it leaves stage 4: carry in the MSB.
  typedef struct packed {
    logic                    cout;
    logic [ADDER_DATA_W-1:0] sum;
  } adder_result_t;

  // Occupancy counter width: one extra bit so that full and empty differ.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/adder_result_buffer_if.sv
// ---------------------------------------------------------------------------
// adder_result_buffer_if
//   Groups the adder-side and consumer-side signals of the result buffer.
//   Signals:
//     in_valid  producer presents an operand pair to the adder
//     stop      stall to the adder and the producer
//     sum/c_out adder stage-4 result
//     out_valid/out_ready/out_sum/out_cout  consumer valid/ready handshake
//     count     FIFO occupancy
//   Modports: slave = the buffer, master = the environment driving it.
// ---------------------------------------------------------------------------
interface adder_result_buffer_if
  import adder_result_buffer_pkg::*;
#(
  parameter int DATA_W = ADDER_DATA_W,
  parameter int CNT_W  = cnt_width(RESBUF_DEPTH)
);
  logic              in_valid;
  logic              stop;
  logic [DATA_W-1:0] sum;
  logic              c_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_cout;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  in_valid, sum, c_out, out_ready,
    output stop, out_valid, out_sum, out_cout, count
  );

  modport master (
    output in_valid, sum, c_out, out_ready,
    input  stop, out_valid, out_sum, out_cout, count
  );
endinterface

// File: rtl/adder_result_buffer_sync_fifo.sv
// ---------------------------------------------------------------------------
// adder_result_buffer_sync_fifo
//   Synchronous FIFO with registered head outputs and occupancy count.
//   A push into an empty FIFO becomes visible on the next cycle.
//   Ports:
//     clk         clock, posedge
//     rst         asynchronous reset, active-low
//     push/din    write din at the tail
//     pop         advance the head (caller guarantees dout_valid)
//     dout        head entry, holds its last value when empty
//     dout_valid  FIFO not empty
//     count       occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module adder_result_buffer_sync_fifo
  import adder_result_buffer_pkg::*;
#(
  parameter int WIDTH = ADDER_DATA_W + 1,
  parameter int DEPTH = RESBUF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         dout_valid,
  output logic [cnt_width(DEPTH)-1:0]  count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] dout_reg;
  logic             dout_valid_reg;
  logic             head_bypass;

  always_comb begin
    rd_ptr_next = rd_ptr_reg + AW'(pop);
    count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
    // The entry being written becomes the head when nothing else remains
    // after this cycle's pop; the array does not hold it yet.
    head_bypass = push && (count_reg == CNT_W'(pop));
  end

  // Storage has no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      dout_valid_reg <= (count_next != '0);
      if (head_bypass)
        dout_reg <= din;
      else if (count_next != '0)
        dout_reg <= mem[rd_ptr_next];
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign count      = count_reg;
endmodule

// File: rtl/adder_result_buffer.sv
// ---------------------------------------------------------------------------
// adder_result_buffer
//   Downstream companion of the 4-stage stallable pipeline adder. Shadows
//   which adder stages hold live operations, captures each {c_out,sum}
//   leaving stage 4 into a FIFO, serves it on a valid/ready handshake and
//   stalls the adder so that no result is lost under backpressure.
//   Ports:
//     clk    clock, posedge
//     rst    asynchronous reset, active-low; release is synchronised here
//     bus    adder_result_buffer_if.slave (in_valid, stop, sum, c_out,
//            out_valid, out_ready, out_sum, out_cout, count)
//   Optional (macro ADDER_RESBUF_STATS_EN):
//     stat_clr      in   zero the stall counter (wins over increment)
//     stall_cycles  out  saturating count of edges with stop=1
// ---------------------------------------------------------------------------
module adder_result_buffer
  import adder_result_buffer_pkg::*;
#(
  parameter int DATA_W = ADDER_DATA_W,
  parameter int LAT    = ADDER_LAT,
  parameter int DEPTH  = RESBUF_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
`ifdef ADDER_RESBUF_STATS_EN
  input  logic        stat_clr,
  output logic [31:0] stall_cycles,
`endif
  adder_result_buffer_if.slave bus
);
  localparam int CNT_W = cnt_width(DEPTH);

  // Reset: asserts immediately, releases two edges after rst rises.
  logic rst_meta_reg, rst_sync_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_meta_reg <= 1'b0;
      rst_sync_reg <= 1'b0;
    end else begin
      rst_meta_reg <= 1'b1;
      rst_sync_reg <= rst_meta_reg;
    end
  end

  logic [LAT-1:0]    vld_reg;
  logic              stall, push, pop;
  logic [DATA_W:0]   fifo_dout;
  logic              fifo_valid;
  logic [CNT_W-1:0]  fifo_count;

  assign pop  = fifo_valid & bus.out_ready;
  // Stall only when a real result sits at the adder output and there is no
  // room for it; a same-cycle pop frees the slot it needs.
  assign stall = vld_reg[LAT-1] & (fifo_count == CNT_W'(DEPTH)) & ~pop;
  assign push  = vld_reg[LAT-1] & ~stall;

  // Shadow of the adder pipeline: advances and holds exactly as it does.
  always_ff @(posedge clk or negedge rst_sync_reg) begin
    if (!rst_sync_reg)
      vld_reg <= '0;
    else if (!stall)
      vld_reg <= {vld_reg[LAT-2:0], bus.in_valid};
  end

  adder_result_buffer_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst_sync_reg),
    .push       (push),
    .din        ({bus.c_out, bus.sum}),
    .pop        (pop),
    .dout       (fifo_dout),
    .dout_valid (fifo_valid),
    .count      (fifo_count)
  );

  assign bus.stop      = stall;
  assign bus.out_valid = fifo_valid;
  assign bus.out_sum   = fifo_dout[DATA_W-1:0];
  assign bus.out_cout  = fifo_dout[DATA_W];
  assign bus.count     = fifo_count;

`ifdef ADDER_RESBUF_STATS_EN
  logic [31:0] stall_cycles_reg;

  always_ff @(posedge clk or negedge rst_sync_reg) begin
    if (!rst_sync_reg)
      stall_cycles_reg <= '0;
    else if (stat_clr)
      stall_cycles_reg <= '0;
    else if (stall && (stall_cycles_reg != '1))
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
  end

  assign stall_cycles = stall_cycles_reg;
`endif
endmodule
